// File: rtl/block_transfer_sequencer.sv
// LDM/STM block transfer sequencer: walks a 16-bit register list in ascending order and
// drives one memory request and register file access per listed register.
module block_transfer_sequencer (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [15:0] reg_list_in,
    input  logic [3:0]  base_reg_in,
    input  logic [31:0] base_addr_in,
    input  logic        load_in,
    input  logic        up_in,
    input  logic        pre_in,
    input  logic        wback_in,
    input  logic [31:0] rf_data_in,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [3:0]  rf_addr_out,
    output logic        rf_write_en_out,
    output logic [31:0] rf_data_out,
    output logic        pc_load_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WB, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  rn_q, rn_d;
    logic [3:0]  idx_q, idx_d;
    logic        load_q, load_d, up_q, up_d, pre_q, pre_d, wback_q, wback_d;
    logic [31:0] base_q, base_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] final_q, final_d;

    logic [4:0]  n_cnt;
    logic [31:0] four_n;
    logic [15:0] pend_clr;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowest16(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    assign n_cnt    = popcount16(list_q);
    assign four_n   = {25'd0, n_cnt, 2'b00};
    assign pend_clr = pend_q & ~(16'h1 << idx_q);

    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        pend_d  = pend_q;
        rn_d    = rn_q;
        idx_d   = idx_q;
        load_d  = load_q;
        up_d    = up_q;
        pre_d   = pre_q;
        wback_d = wback_q;
        base_d  = base_q;
        addr_d  = addr_q;
        final_d = final_q;

        busy_out        = 1'b0;
        done_out        = 1'b0;
        rf_addr_out     = '0;
        rf_write_en_out = 1'b0;
        rf_data_out     = '0;
        pc_load_out     = 1'b0;
        mem_req_out     = 1'b0;
        mem_we_out      = 1'b0;
        mem_addr_out    = '0;
        mem_wdata_out   = '0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    list_d  = reg_list_in;
                    rn_d    = base_reg_in;
                    base_d  = base_addr_in & ~32'h3;
                    load_d  = load_in;
                    up_d    = up_in;
                    pre_d   = pre_in;
                    wback_d = wback_in;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                busy_out = 1'b1;
                final_d  = up_q ? base_q + four_n : base_q - four_n;
                // Lowest register always sits at the lowest address, so decrementing
                // modes start from the bottom of the block.
                case ({up_q, pre_q})
                    2'b10:   addr_d = base_q;
                    2'b11:   addr_d = base_q + 32'd4;
                    2'b00:   addr_d = base_q - four_n + 32'd4;
                    default: addr_d = base_q - four_n;
                endcase
                pend_d  = list_q;
                idx_d   = lowest16(list_q);
                state_d = (n_cnt == 5'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                busy_out      = 1'b1;
                mem_req_out   = 1'b1;
                mem_we_out    = !load_q;
                mem_addr_out  = addr_q;
                rf_addr_out   = idx_q;
                mem_wdata_out = load_q ? 32'd0 : rf_data_in;
                if (mem_ack_in) begin
                    if (load_q) begin
                        rf_data_out = mem_rdata_in;
                        if (idx_q == 4'd15) pc_load_out     = 1'b1;
                        else                rf_write_en_out = 1'b1;
                    end
                    addr_d = addr_q + 32'd4;
                    pend_d = pend_clr;
                    idx_d  = lowest16(pend_clr);
                    if (pend_clr == 16'd0) begin
                        // A load into Rn wins over the writeback.
                        state_d = (wback_q && !(load_q && list_q[rn_q])) ? S_WB : S_DONE;
                    end
                end
            end
            S_WB: begin
                busy_out        = 1'b1;
                rf_addr_out     = rn_q;
                rf_data_out     = final_q;
                rf_write_en_out = 1'b1;
                state_d         = S_DONE;
            end
            S_DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            list_q  <= '0;
            pend_q  <= '0;
            rn_q    <= '0;
            idx_q   <= '0;
            load_q  <= 1'b0;
            up_q    <= 1'b0;
            pre_q   <= 1'b0;
            wback_q <= 1'b0;
            base_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            pend_q  <= pend_d;
            rn_q    <= rn_d;
            idx_q   <= idx_d;
            load_q  <= load_d;
            up_q    <= up_d;
            pre_q   <= pre_d;
            wback_q <= wback_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            final_q <= final_d;
        end
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Scoreboard bench for block_transfer_sequencer with a register file and wait-state memory model.
module tb_block_transfer_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in, start_in, load_in, up_in, pre_in, wback_in, mem_ack_in;
    logic [15:0] reg_list_in;
    logic [3:0]  base_reg_in;
    logic [31:0] base_addr_in, rf_data_in, mem_rdata_in;
    logic        busy_out, done_out, rf_write_en_out, pc_load_out, mem_req_out, mem_we_out;
    logic [3:0]  rf_addr_out;
    logic [31:0] rf_data_out, mem_addr_out, mem_wdata_out;

    block_transfer_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .reg_list_in(reg_list_in),
        .base_reg_in(base_reg_in), .base_addr_in(base_addr_in), .load_in(load_in),
        .up_in(up_in), .pre_in(pre_in), .wback_in(wback_in), .rf_data_in(rf_data_in),
        .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in), .busy_out(busy_out),
        .done_out(done_out), .rf_addr_out(rf_addr_out), .rf_write_en_out(rf_write_en_out),
        .rf_data_out(rf_data_out), .pc_load_out(pc_load_out), .mem_req_out(mem_req_out),
        .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out)
    );

    always #5 clk_in = ~clk_in;

    localparam int EV_ST = 0, EV_LD = 1, EV_RFW = 2, EV_PC = 3;
    typedef struct { int kind; logic [31:0] a; logic [31:0] d; } ev_t;

    ev_t         sbq[$];
    logic [31:0] rf [16];
    logic [31:0] mem_init [logic [31:0]];
    int          checks = 0, failures = 0;
    int          mem_wait = 0, wcnt = 0;

    assign rf_data_in = rf[rf_addr_out];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return ~a;
    endfunction

    function automatic ev_t mk(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.d = d;
        return e;
    endfunction

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_event", 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            chk("ev_kind", 32'(k), 32'(e.kind));
            chk("ev_addr", a, e.a);
            chk("ev_data", d, e.d);
        end
    endtask

    // Register file write port
    always @(posedge clk_in) if (rf_write_en_out) rf[rf_addr_out] = rf_data_out;

    // Memory: acks after mem_wait idle cycles of a held request
    always @(negedge clk_in) begin
        mem_rdata_in = mem_rd(mem_addr_out);
        if (mem_req_out) begin
            if (wcnt >= mem_wait) begin mem_ack_in = 1'b1; wcnt = 0; end
            else begin mem_ack_in = 1'b0; wcnt++; end
        end else begin
            mem_ack_in = 1'b0; wcnt = 0;
        end
    end

    logic        prev_wait = 1'b0, prev_we;
    logic [31:0] prev_addr;
    logic [3:0]  prev_idx;
    always @(negedge clk_in) begin
        #1;
        if (prev_wait) begin
            chk("hold_req",  32'(mem_req_out), 32'd1);
            chk("hold_addr", mem_addr_out, prev_addr);
            chk("hold_we",   32'(mem_we_out), 32'(prev_we));
            chk("hold_idx",  32'(rf_addr_out), 32'(prev_idx));
        end
        prev_wait = mem_req_out && !mem_ack_in && !rst_in;
        prev_addr = mem_addr_out;
        prev_we   = mem_we_out;
        prev_idx  = rf_addr_out;
        if (mem_req_out && mem_ack_in)
            observe(mem_we_out ? EV_ST : EV_LD, mem_addr_out, mem_we_out ? mem_wdata_out : 32'd0);
        if (rf_write_en_out) observe(EV_RFW, {28'd0, rf_addr_out}, rf_data_out);
        if (pc_load_out)     observe(EV_PC, 32'd0, rf_data_out);
    end

    task automatic drive_cmd(input logic [15:0] list, input logic [3:0] rn, input logic [31:0] base,
                             input bit ld, input bit up, input bit pre, input bit wb);
        start_in = 1'b1; reg_list_in = list; base_reg_in = rn; base_addr_in = base;
        load_in = ld; up_in = up; pre_in = pre; wback_in = wb;
    endtask

    task automatic run(input logic [15:0] list, input logic [3:0] rn, input logic [31:0] base,
                       input bit ld, input bit up, input bit pre, input bit wb,
                       input int wt, input bit poke);
        logic [31:0] b, fin, a;
        int n, lat, cyc;
        bit do_wb;
        rf[rn] = base;
        mem_wait = wt;
        b = base & ~32'h3;
        n = $countones(list);
        fin = up ? b + 32'(4 * n) : b - 32'(4 * n);
        if (up) a = pre ? b + 32'd4 : b;
        else    a = pre ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
        do_wb = wb && !(ld && list[rn]) && (n != 0);
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                if (ld) begin
                    sbq.push_back(mk(EV_LD, a, 32'd0));
                    if (i == 15) sbq.push_back(mk(EV_PC, 32'd0, mem_rd(a)));
                    else         sbq.push_back(mk(EV_RFW, 32'(i), mem_rd(a)));
                end else begin
                    sbq.push_back(mk(EV_ST, a, rf[i]));
                end
                a = a + 32'd4;
            end
        end
        if (do_wb) sbq.push_back(mk(EV_RFW, {28'd0, rn}, fin));
        lat = (n == 0) ? 2 : 2 + n * (wt + 1) + (do_wb ? 1 : 0);

        drive_cmd(list, rn, base, ld, up, pre, wb);
        @(posedge clk_in);
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) start_in = 1'b0;
            if (poke && cyc == 2) drive_cmd(16'hFFFF, 4'd0, 32'h0, !ld, !up, pre, 1'b1);
            if (poke && cyc == 3) start_in = 1'b0;
            if (done_out) break;
        end
        chk("done_latency", 32'(cyc), 32'(lat));
        @(negedge clk_in);
        #2;
        chk("done_one_cycle", 32'(done_out), 32'd0);
        chk("idle_after_done", 32'(busy_out), 32'd0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, busy_out, done_out, rf_write_en_out, pc_load_out, mem_req_out, mem_we_out}, 32'd0);
        chk({tag, "_rf_addr"}, 32'(rf_addr_out), 32'd0);
        chk({tag, "_rf_data"}, rf_data_out, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr_out, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_out, 32'd0);
    endtask

    initial begin
        int cyc;
        rst_in = 1'b1; start_in = 1'b0; reg_list_in = '0; base_reg_in = '0; base_addr_in = '0;
        load_in = 1'b0; up_in = 1'b0; pre_in = 1'b0; wback_in = 1'b0;
        mem_ack_in = 1'b0; mem_rdata_in = '0;
        for (int i = 0; i < 16; i++) rf[i] = 32'hC000_0000 + 32'(i);
        repeat (3) @(negedge clk_in);
        #2;
        chk_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // STM IA, zero wait
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        run(16'h000E, 4'd0, 32'h100, 0, 1, 0, 0, 0, 0);
        // LDM DB with writeback
        mem_init[32'h1F8] = 32'hA0; mem_init[32'h1FC] = 32'hB0;
        run(16'h0011, 4'd13, 32'h200, 1, 0, 1, 1, 0, 0);
        // STM IB, 3 wait cycles, start pulse while busy
        run(16'h0001, 4'd5, 32'h40, 0, 1, 1, 0, 3, 1);
        // Empty list, writeback requested
        run(16'h0000, 4'd6, 32'h80, 0, 1, 0, 1, 0, 0);
        // LDM with Rn and R15 in list
        run(16'h8004, 4'd2, 32'h300, 1, 1, 0, 1, 0, 0);
        // STM DA with writeback and unaligned base
        run(16'h00C0, 4'd1, 32'h1002, 0, 0, 0, 1, 1, 0);
        // LDM IA wrapping through zero
        run(16'h0003, 4'd9, 32'hFFFF_FFFC, 1, 1, 0, 1, 0, 0);

        // Reset during the second of four loads
        rf[1] = 32'h500;
        mem_wait = 0;
        sbq.push_back(mk(EV_LD, 32'h500, 32'd0));
        sbq.push_back(mk(EV_RFW, 32'd4, mem_rd(32'h500)));
        sbq.push_back(mk(EV_LD, 32'h504, 32'd0));
        sbq.push_back(mk(EV_RFW, 32'd5, mem_rd(32'h504)));
        drive_cmd(16'h00F0, 4'd1, 32'h500, 1, 1, 0, 0);
        @(posedge clk_in);
        cyc = 0;
        while (cyc < 3) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) start_in = 1'b0;
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        #2;
        chk_all_zero("midrst");
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            #2;
            chk("midrst_no_done", 32'(done_out), 32'd0);
            chk("midrst_idle", 32'(busy_out), 32'd0);
        end
        chk("midrst_sb", 32'(sbq.size()), 32'd0);
        sbq.delete();
        run(16'h000E, 4'd0, 32'h100, 0, 1, 0, 0, 0, 0);

        // Random commands across all modes
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) rf[i] = $urandom;
            run(16'($urandom), 4'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 2)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
